uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver, the far-end partner of the UART transmitter in this design.
//   Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 even-parity
//   bit (parity = ^data), and 1 stop bit (1).
//   Bit timing comes from the runtime byte_rate input. This is the same value
//   programmed into the transmitter.
//   Deserialized bytes, plus parity and framing status, go to the core.
// PARAMETERS
//   DATA_BITS  8  data bits per frame (even parity is always present)
//   SYNC_FF    2  synchronizer depth on rx; minimum 2
// PORTS
//   clk            in   1   system clock
//   rst            in   1   synchronous reset, active-high
//   rx             in   1   serial line, asynchronous; idles high
//   byte_rate      in   32  clk cycles per bit; legal values >= 4
//   rx_data        out  8   last received byte
//   rx_done        out  1   1-cycle pulse: a frame has completed
//   rx_parity_err  out  1   parity status of the last frame
//   rx_frame_err   out  1   stop bit of the last frame was sampled 0
//   rx_busy        out  1   high from start-bit detect until rx_done
// BEHAVIOUR
//   Reset values:
//     - rx_data=0, rx_done=0, both error flags=0, rx_busy=0.
//     - Synchronizer flops = 1; FSM = IDLE; timers = 0.
//   Synchronizer: the FSM sees rx_s, which is rx delayed by SYNC_FF cycles.
//   Timing:
//     - byte_rate is latched into rate_q on start detect.
//     - A later change to byte_rate affects only the next frame.
//   Bit timer:
//     - Counts 0..rate_q-1, then wraps.
//     - A sample strobe fires at count == rate_q-1.
//   FSM states:
//     - IDLE:
//         rx_busy=0.
//         A 1->0 transition of rx_s goes to START: load the timer for a
//         half-bit, rate_q>>1 cycles.
//         A line held low never re-triggers; a 1 must be seen first.
//     - START:
//         At the half-bit strobe, sample rx_s.
//         0 -> go to DATA, with the timer reloaded for a full bit.
//         1 -> glitch: go to IDLE with no rx_done and all outputs unchanged.
//     - DATA:
//         Sample once per full bit, so samples fall mid-bit.
//         Shift into the shift register from the MSB side, so bit0 arrives
//         first.
//         A 4-bit bit counter reaches DATA_BITS-1, then go to PARITY.
//     - PARITY:
//         Sample p. par_err = p ^ (^shift_reg). Go to STOP.
//     - STOP:
//         Sample s, then on the same clk edge:
//           - rx_data <= shift_reg
//           - rx_parity_err <= par_err
//           - rx_frame_err <= ~s
//           - rx_done <= 1 for exactly one cycle
//         Then go to IDLE. Outputs hold until the next rx_done.
//         A data byte with a frame error is still delivered.
//         After a stop bit of 0 (break), IDLE waits for rx_s=1 before
//         re-arming.
//   Latency:
//     - rx_done rises SYNC_FF+1 cycles after the mid-point of the stop bit on
//       the rx pin.
//     - Measured from the start-bit falling edge, that is about 10.5 bit
//       times plus SYNC_FF+1 cycles.
//   Back-to-back frames:
//     - STOP returns to IDLE at mid-stop-bit.
//     - A start edge arriving right after the stop bit is therefore caught.
//     - No idle gap is required.
//   Reset mid-frame: the FSM aborts to IDLE, all outputs go to reset values,
//   and the partial byte is discarded.
//   No overrun tracking: the core must read rx_data before the next rx_done.
// TESTING
//   All cases use byte_rate=16 and drive rx from a bit-accurate model of the
//   transmitter unless stated otherwise.
//   1. Send 0xA5 with parity 0 and stop 1:
//        rx_data=8'hA5, one rx_done pulse, parity_err=0, frame_err=0,
//        rx_busy low after done.
//   2. Send 0x3C with parity forced to 1:
//        rx_data=8'h3C, rx_done pulse, rx_parity_err=1, rx_frame_err=0.
//   3. Send 0x81 with stop forced to 0, then hold rx low for 40 cycles:
//        rx_data=8'h81, rx_frame_err=1, exactly one rx_done,
//        no re-trigger until rx returns high.
//   4. Drive rx low for 4 cycles only (glitch):
//        no rx_done, rx_busy falls within 9 cycles, outputs unchanged.
//   5. Send 0x00 then 0xFF back-to-back with zero idle gap:
//        two rx_done pulses, with values 8'h00 then 8'hFF and no errors.
//   6. Assert rst during data bit 4 of a frame:
//        all outputs read 0 the next cycle, no rx_done.
//        A following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and bit rate in, byte plus status out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [31:0]          byte_rate;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (
    output rx, byte_rate,
    input  rx_data, rx_done, rx_parity_err, rx_frame_err, rx_busy
  );

  modport slave (
    input  rx, byte_rate,
    output rx_data, rx_done, rx_parity_err, rx_frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8E1 UART receiver; rx_done pulses SYNC_FF+1 cycles after the mid-stop-bit point.
// No backpressure: the core must take rx_data before the next rx_done.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SYNC_FF   = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [SYNC_FF-1:0]   sync_q;
  logic                 rx_s;
  logic                 rx_s_q;
  logic [31:0]          rate_q;
  logic [31:0]          timer;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err;
  logic                 strobe;

  assign rx_s   = sync_q[SYNC_FF-1];
  assign strobe = (timer == rate_q - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      sync_q            <= '1;
      rx_s_q            <= 1'b1;
      rate_q            <= '0;
      timer             <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      par_err           <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_done       <= 1'b0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
      bus.rx_busy       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_FF-2:0], bus.rx};
      rx_s_q      <= rx_s;
      bus.rx_done <= 1'b0;

      if (state != IDLE)
        timer <= strobe ? 32'd0 : timer + 32'd1;

      case (state)
        IDLE: begin
          // Edge-triggered so a line stuck low after a break cannot re-arm.
          if (rx_s_q && !rx_s) begin
            rate_q      <= bus.byte_rate;
            timer       <= bus.byte_rate - (bus.byte_rate >> 1);
            bus.rx_busy <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (strobe) begin
            if (!rx_s) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              bus.rx_busy <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        DATA: begin
          if (strobe) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1))
              state <= PARITY;
            else
              bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (strobe) begin
            par_err <= rx_s ^ (^shift_reg);
            state   <= STOP;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a start edge right behind it is caught.
          if (strobe) begin
            bus.rx_data       <= shift_reg;
            bus.rx_parity_err <= par_err;
            bus.rx_frame_err  <= ~rx_s;
            bus.rx_done       <= 1'b1;
            bus.rx_busy       <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-accurate transmitter model drives rx; received frames
// are compared with the frames the model intended to send.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .SYNC_FF(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  int   total = 0;
  int   bad   = 0;
  int   tx_rate = 16;
  rec_t exp_q[$];
  rec_t got_q[$];
  rec_t last_exp;

  always @(negedge clk)
    if (bus.rx_done === 1'b1)
      got_q.push_back({bus.rx_data, bus.rx_parity_err, bus.rx_frame_err});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_bit(input logic v, input int cycles);
    bus.rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Expected flags: parity error exactly when the sent parity bit is inverted,
  // frame error exactly when the stop bit is 0.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_v, input logic scramble);
    drive_bit(1'b0, tx_rate);
    if (scramble) bus.byte_rate = 32'($urandom_range(4, 100));
    for (int i = 0; i < 8; i++) drive_bit(b[i], tx_rate);
    drive_bit((^b) ^ par_flip, tx_rate);
    drive_bit(stop_v, tx_rate);
    bus.byte_rate = 32'(tx_rate);
    exp_q.push_back({b, par_flip, ~stop_v});
  endtask

  task automatic wait_got(input int n, input int limit);
    for (int i = 0; i < limit && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.byte_rate = 32'd16;
    repeat (3) @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.rx_data); end
    total++; if (bus.rx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.rx_done); end
    total++; if (bus.rx_parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus.rx_parity_err); end
    total++; if (bus.rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus.rx_frame_err); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.rx_busy); end
    rst = 1'b0;
    drive_bit(1'b1, 20);
  endtask

  task automatic test_basic();
    rec_t g;
    got_q.delete(); exp_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_got(1, 40);
    repeat (20) @(negedge clk);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", got_q.size()); end
    total++; if (g.d !== exp_q[0].d) begin bad++; $display("FAIL basic_data got=%h want=%h", g.d, exp_q[0].d); end
    total++; if (g.pe !== exp_q[0].pe) begin bad++; $display("FAIL basic_perr got=%b want=%b", g.pe, exp_q[0].pe); end
    total++; if (g.fe !== exp_q[0].fe) begin bad++; $display("FAIL basic_ferr got=%b want=%b", g.fe, exp_q[0].fe); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", bus.rx_busy); end
  endtask

  task automatic test_parity();
    rec_t g;
    got_q.delete(); exp_q.delete();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    wait_got(1, 40);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL parity_count got=%0d want=1", got_q.size()); end
    total++; if (g.d !== exp_q[0].d) begin bad++; $display("FAIL parity_data got=%h want=%h", g.d, exp_q[0].d); end
    total++; if (g.pe !== 1'b1) begin bad++; $display("FAIL parity_perr got=%b want=1", g.pe); end
    total++; if (g.fe !== 1'b0) begin bad++; $display("FAIL parity_ferr got=%b want=0", g.fe); end
  endtask

  task automatic test_break();
    rec_t g;
    got_q.delete(); exp_q.delete();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL break_count got=%0d want=1", got_q.size()); end
    total++; if (g.d !== 8'h81) begin bad++; $display("FAIL break_data got=%h want=81", g.d); end
    total++; if (g.fe !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", g.fe); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL break_retrigger busy=%b want=0", bus.rx_busy); end
    drive_bit(1'b1, 30);
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL break_release_count got=%0d want=1", got_q.size()); end
    last_exp = exp_q[0];
  endtask

  task automatic test_glitch();
    int w;
    got_q.delete(); exp_q.delete();
    drive_bit(1'b0, 4);
    bus.rx = 1'b1;
    total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_detect busy=%b want=1", bus.rx_busy); end
    for (w = 0; w < 9 && bus.rx_busy !== 1'b0; w++) @(negedge clk);
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall busy=%b want=0 after %0d cycles", bus.rx_busy, w); end
    drive_bit(1'b1, 30);
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_done got=%0d want=0", got_q.size()); end
    total++; if (bus.rx_data !== last_exp.d) begin bad++; $display("FAIL glitch_data got=%h want=%h", bus.rx_data, last_exp.d); end
    total++; if (bus.rx_frame_err !== last_exp.fe) begin bad++; $display("FAIL glitch_ferr got=%b want=%b", bus.rx_frame_err, last_exp.fe); end
  endtask

  task automatic test_back_to_back();
    rec_t g0, g1;
    got_q.delete(); exp_q.delete();
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    wait_got(2, 40);
    g0 = (got_q.size() > 0) ? got_q[0] : 'x;
    g1 = (got_q.size() > 1) ? got_q[1] : 'x;
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
    total++; if (g0 !== exp_q[0]) begin bad++; $display("FAIL b2b_first got=%h want=%h", g0, exp_q[0]); end
    total++; if (g1 !== exp_q[1]) begin bad++; $display("FAIL b2b_second got=%h want=%h", g1, exp_q[1]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    rec_t g;
    got_q.delete(); exp_q.delete();
    b = 8'h3B;  // bit 4 is 1, so the line is high while reset is applied
    drive_bit(1'b0, tx_rate);
    for (int i = 0; i < 4; i++) drive_bit(b[i], tx_rate);
    drive_bit(b[4], tx_rate / 2);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", bus.rx_data); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.rx_busy); end
    total++; if ({bus.rx_done, bus.rx_parity_err, bus.rx_frame_err} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b want=000", {bus.rx_done, bus.rx_parity_err, bus.rx_frame_err}); end
    rst = 1'b0;
    drive_bit(1'b1, 40);
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d want=0", got_q.size()); end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_got(1, 40);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    total++; if (g !== exp_q[0]) begin bad++; $display("FAIL rstmid_next got=%h want=%h", g, exp_q[0]); end
  endtask

  task automatic test_random();
    rec_t g;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      logic stop_v;
      tx_rate = $urandom_range(6, 24);
      bus.byte_rate = 32'(tx_rate);
      stop_v = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), stop_v, 1'($urandom));
      if (!stop_v) drive_bit(1'b1, tx_rate);
      else         drive_bit(1'b1, $urandom_range(0, 10));
    end
    wait_got(exp_q.size(), 60);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rand_frame%0d got=%h want=%h", i, g, exp_q[i]); end
    end
    tx_rate = 16;
    bus.byte_rate = 32'd16;
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.byte_rate = 32'd16;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
